// File: rtl/st7920_pkg.sv
// Shared types and constants for the ST7920 refresh scheduler: FSM states,
// init command ROM, display command encodings and the command payload.
package st7920_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_SET_Y,
        ST_SET_X,
        ST_FETCH,
        ST_DATA,
        ST_GAP
    } state_e;

    localparam logic [7:0] CMD_BASIC   = 8'h30;
    localparam logic [7:0] CMD_DISP_ON = 8'h0C;
    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] CMD_EXT     = 8'h34;
    localparam logic [7:0] CMD_GFX_ON  = 8'h36;
    localparam logic [7:0] CMD_ADDR    = 8'h80;

    localparam int unsigned ROW_W    = 6;
    localparam int unsigned COL_W    = 4;
    localparam int unsigned FB_AW    = 10;
    localparam int unsigned NUM_ROWS = 64;
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned INIT_LEN = 6;

    localparam logic [7:0] INIT_ROM [INIT_LEN] = '{
        CMD_BASIC, CMD_BASIC, CMD_DISP_ON, CMD_CLEAR, CMD_EXT, CMD_GFX_ON
    };

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } cmd_t;

endpackage

// File: rtl/st7920_refresh_scheduler_if.sv
// Valid/ready command bus between the scheduler and the serial transmitter.
interface st7920_refresh_scheduler_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rs;
    logic [7:0] cmd_data;

    modport master (output cmd_valid, output cmd_rs, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_rs, input cmd_data, output cmd_ready);
endinterface

// File: rtl/st7920_dirty_tracker.sv
// Per-row dirty vector with set-wins-over-clear update and a round-robin
// search for the next dirty row starting just after the last one served.
module st7920_dirty_tracker
    import st7920_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_valid,
    input  logic [ROW_W-1:0] set_row,
    input  logic             set_all,
    input  logic             clr_valid,
    input  logic [ROW_W-1:0] clr_row,
    output logic             any_dirty,
    output logic [ROW_W-1:0] next_row
);

    logic [NUM_ROWS-1:0] dirty_q;
    logic [ROW_W-1:0]    last_row_q;
    logic [NUM_ROWS-1:0] set_mask;
    logic [NUM_ROWS-1:0] clr_mask;
    logic [ROW_W-1:0]    cand;
    logic                found;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_valid) set_mask[set_row] = 1'b1;
        if (clr_valid) clr_mask[clr_row] = 1'b1;
    end

    // k = 64 wraps back to last_row itself, so it is checked last.
    always_comb begin
        next_row = '0;
        found    = 1'b0;
        cand     = '0;
        for (int k = 1; k <= 64; k++) begin
            cand = last_row_q + 6'(k);
            if (!found && dirty_q[cand]) begin
                next_row = cand;
                found    = 1'b1;
            end
        end
    end

    assign any_dirty = |dirty_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dirty_q    <= '1;
            last_row_q <= 6'd63;
        end else begin
            if (set_all) dirty_q <= '1;
            else         dirty_q <= (dirty_q & ~clr_mask) | set_mask;
            if (clr_valid) last_row_q <= clr_row;
        end
    end

endmodule

// File: rtl/st7920_refresh_scheduler.sv
// ST7920 sequencer: sends the power-up command ROM, then streams dirty
// framebuffer rows (SET_Y, SET_X, 16 data bytes) to the serial transmitter.
module st7920_refresh_scheduler
    import st7920_pkg::*;
#(
    parameter int unsigned CMD_GAP   = 2000,
    parameter int unsigned CLEAR_GAP = 50000
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst_n,
    input  logic                        wr_valid,
    input  logic [FB_AW-1:0]            wr_addr,
    input  logic                        force_refresh,
    output logic [FB_AW-1:0]            fb_rd_addr,
    input  logic [7:0]                  fb_rd_data,
    st7920_refresh_scheduler_if.master  cmd,
    output logic                        init_done,
    output logic                        busy
);

    localparam int unsigned GAP_MAX = (CMD_GAP > CLEAR_GAP) ? CMD_GAP : CLEAR_GAP;
    localparam int unsigned GAP_W   = (GAP_MAX > 0) ? $clog2(GAP_MAX + 1) : 1;

    state_e             state_q;
    state_e             ret_q;
    logic [IDX_W-1:0]   idx_q;
    logic [GAP_W-1:0]   gap_q;
    logic [ROW_W-1:0]   row_q;
    logic [COL_W-1:0]   byte_q;
    logic               cmd_valid_q;
    logic               cmd_rs_q;
    logic [7:0]         cmd_data_q;
    logic [FB_AW-1:0]   fb_rd_addr_q;
    logic               init_done_q;
    logic               busy_q;

    logic               any_dirty;
    logic [ROW_W-1:0]   next_row;
    logic               clr_valid_c;
    logic               hs_c;
    logic               wr_col_unused;

    assign hs_c          = cmd_valid_q & cmd.cmd_ready;
    assign clr_valid_c   = (state_q == ST_IDLE) & any_dirty;
    // Column bits never affect which row is dirty.
    assign wr_col_unused = ^wr_addr[COL_W-1:0];

    st7920_dirty_tracker u_dirty (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .set_valid (wr_valid),
        .set_row   (wr_addr[FB_AW-1:COL_W]),
        .set_all   (force_refresh),
        .clr_valid (clr_valid_c),
        .clr_row   (next_row),
        .any_dirty (any_dirty),
        .next_row  (next_row)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= ST_INIT;
            ret_q        <= ST_INIT;
            idx_q        <= '0;
            gap_q        <= '0;
            row_q        <= '0;
            byte_q       <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_rs_q     <= 1'b0;
            cmd_data_q   <= 8'h00;
            fb_rd_addr_q <= '0;
            init_done_q  <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (!cmd_valid_q) begin
                        cmd_valid_q <= 1'b1;
                        cmd_rs_q    <= 1'b0;
                        cmd_data_q  <= INIT_ROM[idx_q];
                    end else if (cmd.cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        gap_q       <= (cmd_data_q == CMD_CLEAR) ? GAP_W'(CLEAR_GAP) : GAP_W'(CMD_GAP);
                        ret_q       <= (idx_q == IDX_W'(INIT_LEN - 1)) ? ST_IDLE : ST_INIT;
                        idx_q       <= idx_q + 3'd1;
                        state_q     <= ST_GAP;
                    end
                end
                ST_IDLE: begin
                    if (any_dirty) begin
                        row_q       <= next_row;
                        busy_q      <= 1'b1;
                        cmd_valid_q <= 1'b1;
                        cmd_rs_q    <= 1'b0;
                        cmd_data_q  <= CMD_ADDR | {3'b000, next_row[4:0]};
                        state_q     <= ST_SET_Y;
                    end
                end
                ST_SET_Y: begin
                    if (hs_c) begin
                        cmd_valid_q <= 1'b0;
                        gap_q       <= GAP_W'(CMD_GAP);
                        ret_q       <= ST_SET_X;
                        state_q     <= ST_GAP;
                    end
                end
                // The read address is issued at the handshake so the
                // synchronous framebuffer output has settled by FETCH.
                ST_SET_X: begin
                    if (hs_c) begin
                        cmd_valid_q  <= 1'b0;
                        gap_q        <= GAP_W'(CMD_GAP);
                        ret_q        <= ST_FETCH;
                        byte_q       <= '0;
                        fb_rd_addr_q <= {row_q, 4'd0};
                        state_q      <= ST_GAP;
                    end
                end
                ST_FETCH: begin
                    cmd_valid_q <= 1'b1;
                    cmd_rs_q    <= 1'b1;
                    cmd_data_q  <= fb_rd_data;
                    state_q     <= ST_DATA;
                end
                ST_DATA: begin
                    if (hs_c) begin
                        cmd_valid_q <= 1'b0;
                        gap_q       <= GAP_W'(CMD_GAP);
                        state_q     <= ST_GAP;
                        if (byte_q == 4'hF) begin
                            ret_q <= ST_IDLE;
                        end else begin
                            ret_q        <= ST_FETCH;
                            byte_q       <= byte_q + 4'd1;
                            fb_rd_addr_q <= {row_q, byte_q + 4'd1};
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_q != '0) begin
                        gap_q <= gap_q - 1'b1;
                    end else begin
                        state_q <= ret_q;
                        case (ret_q)
                            ST_INIT: begin
                                cmd_valid_q <= 1'b1;
                                cmd_rs_q    <= 1'b0;
                                cmd_data_q  <= INIT_ROM[idx_q];
                            end
                            ST_SET_X: begin
                                cmd_valid_q <= 1'b1;
                                cmd_rs_q    <= 1'b0;
                                cmd_data_q  <= row_q[5] ? (CMD_ADDR | 8'h08) : CMD_ADDR;
                            end
                            ST_IDLE: begin
                                busy_q      <= 1'b0;
                                init_done_q <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign cmd.cmd_valid = cmd_valid_q;
    assign cmd.cmd_rs    = cmd_rs_q;
    assign cmd.cmd_data  = cmd_data_q;
    assign fb_rd_addr    = fb_rd_addr_q;
    assign init_done     = init_done_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_st7920_refresh_scheduler.sv
// Scoreboard bench for the ST7920 refresh scheduler: a row-level model pushes
// expected commands, a bus monitor pops and checks them plus gap timing.
module tb_st7920_refresh_scheduler;
    import st7920_pkg::*;

    localparam int unsigned CMD_GAP   = 3;
    localparam int unsigned CLEAR_GAP = 9;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_valid;
    logic [9:0] wr_addr;
    logic       force_refresh;
    logic [9:0] fb_rd_addr;
    logic [7:0] fb_rd_data;
    logic       init_done;
    logic       busy;

    st7920_refresh_scheduler_if bus ();

    st7920_refresh_scheduler #(.CMD_GAP(CMD_GAP), .CLEAR_GAP(CLEAR_GAP)) dut (
        .sys_clk       (clk),
        .sys_rst_n     (rst_n),
        .wr_valid      (wr_valid),
        .wr_addr       (wr_addr),
        .force_refresh (force_refresh),
        .fb_rd_addr    (fb_rd_addr),
        .fb_rd_data    (fb_rd_data),
        .cmd           (bus),
        .init_done     (init_done),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    logic [7:0] fb_mem [1024];
    always @(posedge clk) fb_rd_data <= fb_mem[fb_rd_addr];

    int   n_checks = 0;
    int   n_fail   = 0;
    cmd_t exp_q [$];
    int   model_last;
    int   ready_mode = 0;
    int   cyc = 0;
    int   hs_count = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transmitter side: always ready, randomly ready, or stalled.
    initial begin
        bus.cmd_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.cmd_ready = 1'b1;
                1:       bus.cmd_ready = ($urandom_range(3) != 0);
                default: bus.cmd_ready = 1'b0;
            endcase
        end
    end

    function automatic void push_cmd(input logic rs, input logic [7:0] d);
        exp_q.push_back('{rs: rs, data: d});
    endfunction

    function automatic void push_init();
        push_cmd(1'b0, 8'h30); push_cmd(1'b0, 8'h30); push_cmd(1'b0, 8'h0C);
        push_cmd(1'b0, 8'h01); push_cmd(1'b0, 8'h34); push_cmd(1'b0, 8'h36);
    endfunction

    // Rows 0..31 live at y=row, x=0; rows 32..63 at y=row-32, x=8.
    function automatic void push_row(input int r);
        push_cmd(1'b0, 8'h80 | 8'(r % 32));
        push_cmd(1'b0, (r >= 32) ? 8'h88 : 8'h80);
        for (int c = 0; c < 16; c++) push_cmd(1'b1, fb_mem[r * 16 + c]);
        model_last = r;
    endfunction

    function automatic void push_rr(input logic [63:0] set);
        int start;
        start = model_last;
        for (int k = 1; k <= 64; k++) begin
            if (set[(start + k) % 64]) push_row((start + k) % 64);
        end
    endfunction

    // Bus monitor: ordering, stability while stalled, drop after handshake, gaps.
    initial begin
        logic prev_valid, prev_hs, skip_gap;
        cmd_t held, last_hs, e;
        int   hs_cyc, exp_gap;
        prev_valid = 0; prev_hs = 0; skip_gap = 1; hs_cyc = 0;
        held = '0; last_hs = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 0; prev_hs = 0; skip_gap = 1; hs_count = 0;
            end else begin
                if (!busy) skip_gap = 1;
                if (prev_hs) check("valid_drop_after_hs", 32'(bus.cmd_valid), 0);
                if (bus.cmd_valid && !prev_valid) begin
                    held = '{rs: bus.cmd_rs, data: bus.cmd_data};
                    if (!skip_gap) begin
                        if (bus.cmd_rs) exp_gap = CMD_GAP + 2;
                        else if (!last_hs.rs && last_hs.data == CMD_CLEAR) exp_gap = CLEAR_GAP + 1;
                        else exp_gap = CMD_GAP + 1;
                        check("gap_cycles", 32'(cyc - hs_cyc), 32'(exp_gap));
                    end
                end
                if (bus.cmd_valid && bus.cmd_ready) begin
                    check("stable_while_waiting", 32'({bus.cmd_rs, bus.cmd_data}), 32'(held));
                    hs_count++;
                    if (exp_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_cmd: got rs=%0b data=0x%0h, expected none", bus.cmd_rs, bus.cmd_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("cmd", 32'({bus.cmd_rs, bus.cmd_data}), 32'(e));
                    end
                    last_hs  = '{rs: bus.cmd_rs, data: bus.cmd_data};
                    hs_cyc   = cyc + 1;
                    skip_gap = 0;
                    prev_hs  = 1;
                end else begin
                    prev_hs = 0;
                end
                prev_valid = bus.cmd_valid;
            end
        end
    end

    task automatic check_reset_vals();
        check("rst_cmd_valid", 32'(bus.cmd_valid), 0);
        check("rst_cmd_rs", 32'(bus.cmd_rs), 0);
        check("rst_cmd_data", 32'(bus.cmd_data), 0);
        check("rst_fb_rd_addr", 32'(fb_rd_addr), 0);
        check("rst_init_done", 32'(init_done), 0);
        check("rst_busy", 32'(busy), 1);
    endtask

    task automatic wait_idle(input int budget);
        int b;
        b = budget;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy) && b > 0) begin
            @(negedge clk);
            b--;
        end
        if (b == 0) check("idle_timeout_pending", 32'(exp_q.size()), 0);
        repeat (20) @(negedge clk);
        check("busy_low_when_idle", 32'(busy), 0);
    endtask

    task automatic wait_hs(input int target, input int budget);
        int b;
        b = budget;
        while (hs_count < target && b > 0) begin
            @(posedge clk);
            b--;
        end
        check("hs_wait_reached", 32'(hs_count >= target), 1);
    endtask

    task automatic do_write(input logic [9:0] a);
        @(posedge clk); #1;
        wr_valid = 1'b1; wr_addr = a;
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    // First write starts a refresh of its row; later writes land during it.
    task automatic write_burst(input int n, input bit with_row5);
        logic [9:0]  addrs [$];
        int          dly [$];
        logic [9:0]  a0;
        logic [63:0] set;
        set = '0;
        a0  = with_row5 ? 10'h050 : 10'($urandom_range(1023));
        for (int i = 0; i < n; i++) begin
            addrs.push_back(10'($urandom_range(1023)));
            dly.push_back($urandom_range(3));
        end
        if (with_row5) begin
            addrs.push_back(10'h052);
            dly.push_back(20);
        end
        push_row(int'(a0[9:4]));
        foreach (addrs[i]) set[addrs[i][9:4]] = 1'b1;
        push_rr(set);
        do_write(a0);
        foreach (addrs[i]) begin
            repeat (dly[i]) @(posedge clk);
            do_write(addrs[i]);
        end
        wait_idle(20000);
    endtask

    initial begin
        int hs_before;
        wr_valid = 1'b0; wr_addr = '0; force_refresh = 1'b0; rst_n = 1'b0;
        for (int i = 0; i < 1024; i++) fb_mem[i] = 8'(i);
        model_last = 63;
        #23;
        check_reset_vals();
        push_init();
        push_rr('1);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("first_valid", 32'(bus.cmd_valid), 1);
        check("first_data", 32'(bus.cmd_data), 32'h30);

        // Reset during row 10's data bytes: init and all rows replay.
        wait_hs(6 + 10 * 18 + 2 + 5, 5000);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_vals();
        exp_q.delete();
        model_last = 63;
        push_init();
        push_rr('1);
        @(negedge clk); rst_n = 1'b1;
        wait_idle(20000);
        check("init_done_after_init", 32'(init_done), 1);

        // Single write while idle refreshes only row 47.
        push_row(47);
        do_write(10'h2F5);
        wait_idle(5000);

        ready_mode = 1;
        write_burst(3, 1'b1);
        for (int it = 0; it < 3; it++) write_burst($urandom_range(1, 6), 1'b0);

        // New framebuffer content, force refresh, with a long mid-row stall.
        for (int i = 0; i < 1024; i++) fb_mem[i] = 8'($urandom);
        push_rr('1);
        @(posedge clk); #1 force_refresh = 1'b1;
        @(posedge clk); #1 force_refresh = 1'b0;
        wait_hs(hs_count + 100, 5000);
        ready_mode = 2;
        repeat (2) @(posedge clk);
        hs_before = hs_count;
        repeat (500) @(posedge clk);
        #2;
        check("stall_valid_held", 32'(bus.cmd_valid), 1);
        check("stall_no_handshake", 32'(hs_count), 32'(hs_before));
        ready_mode = 1;
        wait_idle(30000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
